// File: rtl/mc_pkg.sv
// mc_pkg: state enum, instruction encodings, ALU op codes and select encodings shared by the multicycle controller and ALU.
package mc_pkg;
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEXEC, S_RTWB, S_BRANCH, S_JUMP, S_IMMEXEC, S_IMMWB
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;
  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_REG    = 1'b1;
  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational opcode/funct to ALU op decode with illegal flag.
// Immediate-format ops decode only when MC_CTRL_IMM_EN is defined.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       zext_o,
  output logic       illegal_o
);
  always_comb begin
    alu_op_o = ALU_AND;
    zext_o = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE:
        case (funct_i)
          FN_ADD:  alu_op_o = ALU_ADD;
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_XOR:  alu_op_o = ALU_XOR;
          FN_NOR:  alu_op_o = ALU_NOR;
          FN_SLT:  alu_op_o = ALU_SLT;
          default: illegal_o = 1'b1;
        endcase
`ifdef MC_CTRL_IMM_EN
      OP_ADDI: alu_op_o = ALU_ADD;
      OP_ANDI: begin
        alu_op_o = ALU_AND;
        zext_o = 1'b1;
      end
      OP_ORI: begin
        alu_op_o = ALU_OR;
        zext_o = 1'b1;
      end
      OP_SLTI: alu_op_o = ALU_SLT;
`endif
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control FSM driving ALU selects and all core write enables.
// Define MC_CTRL_IMM_EN to build addi/andi/ori/slti support (IMMEXEC/IMMWB).
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zf_i,
  input  logic       mem_ready_i,
  output logic [3:0] alu_op_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       imm_zext_o,
  output logic [1:0] pc_src_o,
  output logic       pc_en_o,
  output logic       iord_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       ir_we_o,
  output logic       reg_we_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       illegal_o
);
  state_e state_q, state_d;
  logic [3:0] dec_op;
  logic dec_zext, dec_ill;
  mc_alu_dec u_dec (.opcode_i(opcode_i), .funct_i(funct_i), .alu_op_o(dec_op), .zext_o(dec_zext), .illegal_o(dec_ill));
  always_comb begin
    state_d = state_q;
    alu_op_o = ALU_AND;
    alu_src_a_o = SRCA_PC;
    alu_src_b_o = SRCB_REG;
    imm_zext_o = 1'b0;
    pc_src_o = PC_ALU;
    pc_en_o = 1'b0;
    iord_o = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    ir_we_o = 1'b0;
    reg_we_o = 1'b0;
    reg_dst_o = 1'b0;
    mem_to_reg_o = 1'b0;
    illegal_o = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req_o = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        alu_op_o = ALU_ADD;
        ir_we_o = mem_ready_i;
        pc_en_o = mem_ready_i;
        state_d = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        alu_op_o = ALU_ADD;
        case (opcode_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_IMM_EN
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEXEC;
`endif
          default: begin
            illegal_o = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_REG;
        alu_src_b_o = SRCB_IMM;
        alu_op_o = ALU_ADD;
        state_d = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        iord_o = 1'b1;
        state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_we_o = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o = 1'b1;
        iord_o = 1'b1;
        state_d = mem_ready_i ? S_FETCH : S_MEMWR;
      end
      S_RTEXEC: begin
        alu_src_a_o = SRCA_REG;
        alu_op_o = dec_op;
        illegal_o = dec_ill;
        state_d = dec_ill ? S_FETCH : S_RTWB;
      end
      S_RTWB: begin
        reg_we_o = 1'b1;
        reg_dst_o = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = SRCA_REG;
        alu_op_o = ALU_SUB;
        pc_src_o = PC_ALUOUT;
        pc_en_o = zf_i;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_src_o = PC_JUMP;
        pc_en_o = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MC_CTRL_IMM_EN
      S_IMMEXEC: begin
        alu_src_a_o = SRCA_REG;
        alu_src_b_o = SRCB_IMM;
        alu_op_o = dec_op;
        imm_zext_o = dec_zext;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        reg_we_o = 1'b1;
        state_d = S_FETCH;
      end
`endif
      default: state_d = S_RST;
    endcase
  end
  // Outputs decode from state_q, so async reset to RST zeroes them immediately.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= S_RST;
    else state_q <= state_d;
`ifndef MC_CTRL_IMM_EN
  logic unused_zext;
  assign unused_zext = dec_zext;
`endif
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control FSM for the 32-bit MIPS-subset datapath. It is the initiator side of the ALU interface: it sequences fetch, decode, execute, memory and writeback. It drives the ALU operation code and operand selects, and it consumes the ALU zero flag to resolve branches. It sits beside the datapath and owns every register/memory write enable in the core.

## Interface
Parameters:
- none (all encodings fixed in package)

Ports:
- clk_i  in  1  core clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- opcode_i  in  6  instr[31:26] from instruction register
- funct_i  in  6  instr[5:0] from instruction register
- zf_i  in  1  ALU zero flag (combinational from ALU)
- mem_ready_i  in  1  memory completes access this cycle
- alu_op_o  out  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, XOR 1101
- alu_src_a_o  out  1  0=PC, 1=reg A
- alu_src_b_o  out  2  0=reg B, 1=const 4, 2=imm, 3=imm<<2
- imm_zext_o  out  1  zero-extend (1) vs sign-extend (0) immediate
- pc_src_o  out  2  0=ALU result, 1=ALUOut, 2=jump target
- pc_en_o  out  1  PC load enable
- iord_o  out  1  memory address: 0=PC, 1=ALUOut
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  memory write
- ir_we_o  out  1  instruction register load
- reg_we_o  out  1  register file write
- reg_dst_o  out  1  0=rt, 1=rd
- mem_to_reg_o  out  1  0=ALUOut, 1=MDR
- illegal_o  out  1  one-cycle pulse on unsupported opcode/funct

## Operation
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BRANCH, JUMP, IMMEXEC, IMMWB.
- RST: all outputs 0; unconditionally → FETCH next cycle.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0.
  - Holds until mem_ready_i. In that cycle ir_we=1 and pc_en=1, then → DECODE.
  - ir_we and pc_en are 0 in waiting cycles.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target → ALUOut). Dispatch on opcode_i:
  - 100011 → MEMADR
  - 101011 → MEMADR
  - 000000 → RTEXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000/001100/001101/001010 → IMMEXEC (only with macro)
  - Otherwise: illegal_o=1 for one cycle, → FETCH.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=ADD. lw → MEMRD; sw → MEMWR.
- MEMRD: mem_req=1, iord=1. Waits for mem_ready_i, then → MEMWB.
- MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1; → FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Waits for mem_ready_i, then → FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=0. alu_op decoded from funct_i:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT.
  - Any other funct: illegal_o=1, alu_op=0000, → FETCH with no writeback.
- RTWB: reg_we=1, reg_dst=1, mem_to_reg=0; → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1, pc_en=zf_i (combinational); → FETCH.
- JUMP: pc_src=2, pc_en=1; → FETCH.
- IMMEXEC: alu_src_a=1, alu_src_b=2.
  - addi: ADD, sign-extend.
  - andi: AND, zero-extend.
  - ori: OR, zero-extend.
  - slti: SLT, sign-extend.
- IMMWB: reg_we=1, reg_dst=0, mem_to_reg=0; → FETCH.
- Every output not listed for a state is 0.

## Timing
- State is registered. All outputs are Moore decodes of state plus latched opcode/funct.
- Exceptions: pc_en_o in BRANCH (follows zf_i), and ir_we_o/pc_en_o in FETCH (gated by mem_ready_i).
- Zero-wait CPI: R 4, lw 5, sw 4, beq 3, j 3, imm 4. Each mem_ready_i=0 cycle adds one.
- opcode_i/funct_i are sampled only in DECODE and RTEXEC/IMMEXEC. They are stable from the IR after FETCH.
- Reset deassertion mid-instruction: the FSM restarts at RST and no partial writeback occurs. rst_ni low forces all outputs 0 asynchronously.
- mem_req_o stays asserted continuously while waiting. It deasserts the cycle after mem_ready_i is seen.

## Configuration
- MC_CTRL_IMM_EN defined: addi/andi/ori/slti decode to IMMEXEC/IMMWB; imm_zext_o is driven.
- MC_CTRL_IMM_EN undefined: IMMEXEC/IMMWB are not built, those opcodes are illegal (illegal_o pulse, → FETCH), and imm_zext_o is tied 0.

## Structure
- Package mc_pkg holds:
  - state enum
  - opcode and funct localparams
  - ALU op codes
  - src-select encodings
- The ALU op codes in mc_pkg are shared with the ALU.
- Sub-module mc_alu_dec: combinational funct/opcode → alu_op plus illegal flag. It is instantiated in mc_ctrl and reused by the pipelined core later.

## Test plan
- Reset low mid-MEMRD, then release → all outputs 0 during reset; RST one cycle, then FETCH with mem_req_o=1.
- add (opcode 0, funct 0x20), mem_ready_i=1 → states FETCH, DECODE, RTEXEC (alu_op 0010), RTWB (reg_we=1, reg_dst=1); 4 cycles.
- lw with mem_ready_i low 2 cycles in MEMRD → MEMRD lasts 3 cycles, mem_req_o held high, then MEMWB with mem_to_reg=1; 7 cycles total.
- beq with zf_i=1, then zf_i=0 → pc_en_o=1 in BRANCH (pc_src=1), then pc_en_o=0; each 3 cycles.
- R-type with funct 0x3F → illegal_o pulses in RTEXEC, reg_we never asserted, next state FETCH.
- ori (001101) with macro defined → alu_op 0001, imm_zext_o=1, IMMWB reg_we=1. Without macro → illegal_o in DECODE.
